// File: rtl/mult_div_unit.sv
// mult_div_unit: HI/LO registers plus a fixed-latency multiply/divide unit.
// Results are computed up front and then held pending until the latency has elapsed.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        req,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ?
    MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [CW-1:0] MUL_N =
    CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N =
    CW'(DIV_CYCLES);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] ZERO = '0;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e        state;
  logic [CW-1:0] count;
  logic [31:0]   pend_hi;
  logic [31:0]   pend_lo;
  logic          pend_wr;

  logic          accept;
  logic          is_long;
  logic [CW-1:0] n_load;
  logic          res_wr;
  logic [31:0]   res_hi;
  logic [31:0]   res_lo;
  logic          wr_hi;
  logic          wr_lo;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;

  logic        sgn;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] num;
  logic [31:0] den;
  logic [31:0] den_safe;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        div_zero;

  assign accept = start & ~req & ~busy;

  assign prod_s =
    $signed({{32{rs_data[31]}}, rs_data}) *
    $signed({{32{rt_data[31]}}, rt_data});

  assign prod_u =
    {32'd0, rs_data} * {32'd0, rt_data};

  // Signed divide via magnitudes; the
  // 0x80000000 / -1 case falls out as
  // quotient 0x80000000, remainder 0.
  assign sgn = (mdu_op == OP_DIV);

  assign a_mag = rs_data[31] ?
    (~rs_data + 32'd1) : rs_data;
  assign b_mag = rt_data[31] ?
    (~rt_data + 32'd1) : rt_data;

  assign num = sgn ? a_mag : rs_data;
  assign den = sgn ? b_mag : rt_data;

  assign div_zero = (rt_data == 32'd0);
  assign den_safe = div_zero ? 32'd1 : den;

  assign uq = num / den_safe;
  assign ur = num % den_safe;

  assign quot =
    (sgn & (rs_data[31] ^ rt_data[31])) ?
    (~uq + 32'd1) : uq;
  assign rem = (sgn & rs_data[31]) ?
    (~ur + 32'd1) : ur;

  // Decode the offered op into its result,
  // latency and direct HI/LO writes.
  always_comb begin
    is_long = 1'b0;
    n_load  = ZERO;
    res_wr  = 1'b0;
    res_hi  = 32'd0;
    res_lo  = 32'd0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    case (mdu_op)
      OP_MULT: begin
        is_long = 1'b1;
        n_load  = MUL_N;
        res_wr  = 1'b1;
        res_hi  = prod_s[63:32];
        res_lo  = prod_s[31:0];
      end
      OP_MULTU: begin
        is_long = 1'b1;
        n_load  = MUL_N;
        res_wr  = 1'b1;
        res_hi  = prod_u[63:32];
        res_lo  = prod_u[31:0];
      end
      OP_DIV, OP_DIVU: begin
        is_long = 1'b1;
        n_load  = DIV_N;
        res_wr  = ~div_zero;
        res_hi  = rem;
        res_lo  = quot;
      end
      OP_MTHI: wr_hi = 1'b1;
      OP_MTLO: wr_lo = 1'b1;
      default: begin
        is_long = 1'b0;
      end
    endcase
  end

  // Two-state sequencer: load on accept,
  // count down, commit pending on last cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count   <= ZERO;
      busy    <= 1'b0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
      hi_out  <= 32'd0;
      lo_out  <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (is_long) begin
              state   <= RUN;
              count   <= n_load;
              busy    <= 1'b1;
              pend_hi <= res_hi;
              pend_lo <= res_lo;
              pend_wr <= res_wr;
            end
            if (wr_hi) hi_out <= rs_data;
            if (wr_lo) lo_out <= rs_data;
          end
        end
        RUN: begin
          if (count == ONE) begin
            state <= IDLE;
            count <= ZERO;
            busy  <= 1'b0;
            if (pend_wr) begin
              hi_out <= pend_hi;
              lo_out <= pend_lo;
            end
          end else begin
            count <= count - ONE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed scoreboard bench.
// Expected HI/LO/latency come from a behavioural model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        req;
  logic        busy;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  mult_div_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .mdu_op(mdu_op),
    .rs_data(rs_data),
    .rt_data(rt_data),
    .req(req),
    .busy(busy),
    .hi_out(hi_out),
    .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp_v
  );
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp_v);
    end
  endtask

  task automatic model(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        rq,
    output exp_t        e
  );
    longint      sp;
    logic [63:0] up;
    int          sa;
    int          sbv;
    e.hi  = m_hi;
    e.lo  = m_lo;
    e.cyc = 0;
    if (!rq) begin
      case (op)
        3'd1: begin
          sp = longint'($signed(a)) *
               longint'($signed(b));
          e.hi  = sp[63:32];
          e.lo  = sp[31:0];
          e.cyc = 5;
        end
        3'd2: begin
          up = {32'd0, a} * {32'd0, b};
          e.hi  = up[63:32];
          e.lo  = up[31:0];
          e.cyc = 5;
        end
        3'd3: begin
          e.cyc = 10;
          if (b == 32'd0) begin
            e.cyc = 10;
          end else if (a == 32'h8000_0000 &&
                       b == 32'hFFFF_FFFF) begin
            e.lo = 32'h8000_0000;
            e.hi = 32'd0;
          end else begin
            sa   = $signed(a);
            sbv  = $signed(b);
            e.lo = 32'(sa / sbv);
            e.hi = 32'(sa % sbv);
          end
        end
        3'd4: begin
          e.cyc = 10;
          if (b != 32'd0) begin
            e.lo = a / b;
            e.hi = a % b;
          end
        end
        3'd5: e.hi = a;
        3'd6: e.lo = a;
        default: e.cyc = 0;
      endcase
    end
  endtask

  task automatic drive(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        rq
  );
    @(negedge clk);
    start   = 1'b1;
    mdu_op  = op;
    rs_data = a;
    rt_data = b;
    req     = rq;
    @(negedge clk);
    start  = 1'b0;
    req    = 1'b0;
    mdu_op = 3'd0;
  endtask

  task automatic finish_op(input string tag,
                           input int    already);
    exp_t g;
    int   cnt;
    cnt = already;
    while (busy === 1'b1 && cnt < 200) begin
      chk({tag, "_hold_hi"}, hi_out, m_hi);
      chk({tag, "_hold_lo"}, lo_out, m_lo);
      cnt++;
      @(negedge clk);
    end
    g = sb.pop_front();
    chk({tag, "_busy_cycles"},
        32'(cnt), 32'(g.cyc));
    chk({tag, "_hi"}, hi_out, g.hi);
    chk({tag, "_lo"}, lo_out, g.lo);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    m_hi = g.hi;
    m_lo = g.lo;
  endtask

  task automatic run_op(
    input string       tag,
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        rq
  );
    exp_t e;
    model(op, a, b, rq, e);
    sb.push_back(e);
    drive(op, a, b, rq);
    finish_op(tag, 0);
  endtask

  initial begin
    exp_t e;
    reset   = 1'b1;
    start   = 1'b0;
    mdu_op  = 3'd0;
    rs_data = 32'd0;
    rt_data = 32'd0;
    req     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_hi", hi_out, 32'd0);
    chk("reset_lo", lo_out, 32'd0);

    run_op("mult", 3'd1,
           32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    run_op("multu", 3'd2,
           32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    run_op("div_neg7", 3'd3,
           32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    run_op("div_ovf", 3'd3,
           32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("mult_big", 3'd1,
           32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
    run_op("divu_zero", 3'd4,
           32'h0000_1234, 32'h0000_0000, 1'b0);
    run_op("div_zero", 3'd3,
           32'hFFFF_0000, 32'h0000_0000, 1'b0);
    run_op("divu", 3'd4,
           32'hFFFF_FFF0, 32'h0000_0007, 1'b0);
    run_op("div_pos_neg", 3'd3,
           32'h0000_0007, 32'hFFFF_FFFE, 1'b0);
    run_op("div_neg_neg", 3'd3,
           32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0);
    run_op("mult_req", 3'd1,
           32'h0000_0003, 32'h0000_0004, 1'b1);
    run_op("mthi_req", 3'd5,
           32'h1111_1111, 32'd0, 1'b1);
    run_op("mthi", 3'd5,
           32'hDEAD_BEEF, 32'd0, 1'b0);
    run_op("mtlo", 3'd6,
           32'h1234_5678, 32'd0, 1'b0);
    run_op("nop", 3'd0,
           32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("rsvd", 3'd7,
           32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    // MTLO offered while busy, then a flush
    // request mid-run; neither may disturb it.
    model(3'd1, 32'd3, 32'd4, 1'b0, e);
    sb.push_back(e);
    drive(3'd1, 32'd3, 32'd4, 1'b0);
    chk("drop_busy1", 32'(busy), 32'd1);
    start   = 1'b1;
    mdu_op  = 3'd6;
    rs_data = 32'hAAAA_AAAA;
    @(negedge clk);
    start  = 1'b0;
    mdu_op = 3'd0;
    req    = 1'b1;
    @(negedge clk);
    req = 1'b0;
    finish_op("mtlo_busy", 2);

    // Reset in busy cycle 4 of a DIV.
    run_op("mthi2", 3'd5,
           32'h0000_0055, 32'd0, 1'b0);
    drive(3'd3, 32'd100, 32'd7, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_busy4", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_hi", hi_out, 32'd0);
    chk("rst_mid_lo", lo_out, 32'd0);
    repeat (15) @(negedge clk);
    chk("rst_late_busy", 32'(busy), 32'd0);
    chk("rst_late_hi", hi_out, 32'd0);
    chk("rst_late_lo", lo_out, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;

    run_op("post_rst_multu", 3'd2,
           32'h0001_0000, 32'h0001_0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
